debug_trace_uart: RTL and testbench
===================================

Name: debug_trace_uart

Overview:
- Consumer for the CPU debug bus (debug_pc_out, debug_instruction_out, debug_output_acc).
- Detects every PC change and captures a snapshot into a small FIFO.
- Drains each snapshot as a fixed-format byte frame on an 8N1 UART line, giving board-level instruction trace.
- Sits beside the CPU core in the FPGA top level and shares its 50 MHz clock.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (115200 baud at 50 MHz); minimum 2.
- FIFO_DEPTH, 4, snapshot FIFO entries; must be a power of two, minimum 2.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk_50mhz  in  1  system clock.
- key0  in  1  reset: synchronous, active-high. The top level inverts key0_n to produce it.
- trace_en  in  1  capture enable; level-sensitive.
- debug_pc_out  in  8  CPU program counter.
- debug_instruction_out  in  16  CPU current instruction.
- debug_output_acc  in  8  CPU accumulator.
- uart_tx  out  1  serial trace output; idles high.
- trace_busy  out  1  high while a frame is in flight or the FIFO is non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_count  out  8  snapshots lost to a full FIFO; saturates at 8'hFF.

Behaviour:
- Reset values (on any clk_50mhz edge with key0=1):
  - uart_tx=1, trace_busy=0, fifo_level=0, drop_count=0.
  - FIFO emptied, FSM=IDLE.
  - pc_prev register cleared; first_q flag set.
- Capture (cycle N): capture occurs when trace_en=1 and either (debug_pc_out != pc_prev) or first_q=1.
  - Snapshot = {pc, instr, acc} sampled in cycle N.
  - pc_prev updates every cycle, whatever the state of trace_en.
  - first_q clears on the first capture. It sets again on any cycle with trace_en=0, so the first cycle after re-enable always captures.
- FIFO push: happens at N+1 (registered).
  - If the FIFO is full at N+1, the push is dropped and drop_count increments, saturating at 255.
  - Fullness is evaluated before a same-cycle pop, so a push and pop in the same cycle at full still drops.
  - A push and pop in the same cycle at non-full both succeed; level is unchanged.
- Transmit FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE -> LOAD when FIFO non-empty. LOAD pops one entry and latches the frame bytes (1 cycle).
  - LOAD -> START: uart_tx=0 for CLKS_PER_BIT cycles.
  - START -> DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - DATA -> STOP: uart_tx=1 for CLKS_PER_BIT cycles.
  - STOP -> START for the next byte; STOP -> IDLE after the last byte.
- Frame contents: SYNC_BYTE, PC, INSTR[15:8], INSTR[7:0], ACC; 5 bytes, no gap between bytes.
- Latency: capture at N -> FIFO write N+1 -> LOAD at N+2 -> uart_tx falls at the N+3 edge.
- Frame length: 5*10*CLKS_PER_BIT cycles.
  - IDLE is revisited for 1 cycle between frames, so back-to-back frames are separated by exactly 2 idle-high cycles (IDLE + LOAD).
- trace_en falling mid-frame: the current frame completes and the queued FIFO entries still drain; no new captures.
- Reset mid-frame: frame aborted; uart_tx=1 from the first reset edge.

Optional Feature:
- Macro: TRACE_CHECKSUM_EN.
- Defined: a sixth byte is appended, equal to the XOR of PC, INSTR[15:8], INSTR[7:0] and ACC. Frame length becomes 60*CLKS_PER_BIT cycles.
- Undefined: 5-byte frame; no checksum logic is synthesized.

Test Plan:
- Reset: hold key0=1 for 5 cycles, then release with the debug bus stable and trace_en=0 -> uart_tx=1, trace_busy=0, fifo_level=0, drop_count=0 for 100 cycles.
- Single frame (CLKS_PER_BIT=4): trace_en=1, PC 0x00->0x01 with instr 0x1234, acc 0x56 -> bytes A5,01,12,34,56.
  - Each byte is 40 cycles.
  - The start bit begins 3 cycles after the capture cycle (first_q capture of PC 0x00 precedes it; check its frame first).
- Burst (FIFO_DEPTH=4, CLKS_PER_BIT=4, first_q already consumed): PC steps 0x01..0x06 on 6 consecutive cycles -> frames for PCs 01..05 transmitted in order; PC 06 dropped; drop_count=1; peak fifo_level=4.
- Saturation: keep the FIFO full and present 300 further PC changes -> drop_count=8'hFF and holds there.
- Reset mid-frame: assert key0 during the DATA bits of byte 2 -> uart_tx=1 from the next edge, fifo_level=0; no further frame until a new capture.
- TRACE_CHECKSUM_EN defined: stimulus as the single-frame test -> bytes A5,01,12,34,56,71; frame length 240 cycles.

Source files
------------

// File: rtl/debug_trace_uart.sv
// Instruction-trace tap: snapshots the CPU debug bus on every PC change and streams each one as a framed 8N1 UART record.
// Define TRACE_CHECKSUM_EN to append an XOR checksum byte to every frame.
module debug_trace_uart #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                          clk_50mhz,
    input  logic                          key0,
    input  logic                          trace_en,
    input  logic [7:0]                    debug_pc_out,
    input  logic [15:0]                   debug_instruction_out,
    input  logic [7:0]                    debug_output_acc,
    output logic                          uart_tx,
    output logic                          trace_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef TRACE_CHECKSUM_EN
    localparam int NUM_BYTES = 6;
`else
    localparam int NUM_BYTES = 5;
`endif
    localparam int REST_W = (NUM_BYTES - 1) * 8;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BYTE_LAST = 3'(NUM_BYTES - 1);
    localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} tx_state_t;

    tx_state_t         state;
    logic [7:0]        pc_prev;
    logic              first_q;
    logic              capture;
    logic              push_q;
    logic [31:0]       push_data_q;
    logic [31:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              fifo_full;
    logic              push_ok;
    logic              pop;
    logic [31:0]       head;
    logic [CW-1:0]     clk_cnt;
    logic [2:0]        bit_idx;
    logic [2:0]        byte_idx;
    logic [7:0]        tx_byte;
    logic [REST_W-1:0] frame_rest;
    logic [REST_W-1:0] frame_next;

    assign capture    = trace_en && ((debug_pc_out != pc_prev) || first_q);
    assign fifo_full  = (count == FULL_LVL);
    assign push_ok    = push_q && !fifo_full;
    assign pop        = (state == LOAD);
    assign head       = mem[rd_ptr];
    assign fifo_level = count;
    assign trace_busy = (state != IDLE) || (count != '0);

`ifdef TRACE_CHECKSUM_EN
    logic [7:0] checksum;
    assign checksum   = head[31:24] ^ head[23:16] ^ head[15:8] ^ head[7:0];
    assign frame_next = {head, checksum};
`else
    assign frame_next = head;
`endif

    // Snapshot is registered one cycle before it reaches the FIFO; first_q forces a capture after every enable.
    always_ff @(posedge clk_50mhz) begin
        if (key0) begin
            pc_prev     <= '0;
            first_q     <= 1'b1;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            pc_prev     <= debug_pc_out;
            push_q      <= capture;
            push_data_q <= {debug_pc_out, debug_instruction_out, debug_output_acc};
            if (!trace_en)
                first_q <= 1'b1;
            else if (capture)
                first_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (push_ok)
            mem[wr_ptr] <= push_data_q;
    end

    // Fullness is judged before the same-cycle pop, so a push into a full FIFO always drops.
    always_ff @(posedge clk_50mhz) begin
        if (key0) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)
                count <= count + 1'b1;
            else if (!push_ok && pop)
                count <= count - 1'b1;
            if (push_q && fifo_full && (drop_count != 8'hFF))
                drop_count <= drop_count + 8'd1;
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (key0) begin
            state      <= IDLE;
            uart_tx    <= 1'b1;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            tx_byte    <= '0;
            frame_rest <= '0;
        end else begin
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (count != '0)
                        state <= LOAD;
                end
                LOAD: begin
                    tx_byte    <= SYNC_BYTE;
                    frame_rest <= frame_next;
                    byte_idx   <= '0;
                    clk_cnt    <= '0;
                    uart_tx    <= 1'b0;
                    state      <= START;
                end
                START: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        uart_tx <= tx_byte[0];
                        tx_byte <= {1'b0, tx_byte[7:1]};
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= tx_byte[0];
                            tx_byte <= {1'b0, tx_byte[7:1]};
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (byte_idx == BYTE_LAST) begin
                            state <= IDLE;
                        end else begin
                            byte_idx   <= byte_idx + 3'd1;
                            tx_byte    <= frame_rest[REST_W-1 -: 8];
                            frame_rest <= frame_rest << 8;
                            uart_tx    <= 1'b0;
                            state      <= START;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_trace_uart.sv
// Scoreboard bench for debug_trace_uart: expected frame bytes are queued at stimulus time and matched by a UART receiver.
module tb_debug_trace_uart;

    localparam int C     = 4;
    localparam int DEPTH = 4;
`ifdef TRACE_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif

    logic        clk = 1'b0;
    logic        key0 = 1'b1;
    logic        trace_en = 1'b0;
    logic [7:0]  debug_pc = 8'h00;
    logic [15:0] debug_instr = 16'h1234;
    logic [7:0]  debug_acc = 8'h56;
    logic        uart_tx;
    logic        trace_busy;
    logic [2:0]  fifo_level;
    logic [7:0]  drop_count;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          cap_cyc = 0;
    int          peak = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  exp_q[$];
    int          starts_q[$];

    debug_trace_uart #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
        .clk_50mhz             (clk),
        .key0                  (key0),
        .trace_en              (trace_en),
        .debug_pc_out          (debug_pc),
        .debug_instruction_out (debug_instr),
        .debug_output_acc      (debug_acc),
        .uart_tx               (uart_tx),
        .trace_busy            (trace_busy),
        .fifo_level            (fifo_level),
        .drop_count            (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic pushFrame(input logic [7:0] pc, input logic [15:0] instr, input logic [7:0] acc);
        exp_q.push_back(8'hA5);
        exp_q.push_back(pc);
        exp_q.push_back(instr[15:8]);
        exp_q.push_back(instr[7:0]);
        exp_q.push_back(acc);
`ifdef TRACE_CHECKSUM_EN
        exp_q.push_back(pc ^ instr[15:8] ^ instr[7:0] ^ acc);
`endif
    endtask

    task automatic applyStimulus(input logic en, input logic [7:0] pc, input logic [15:0] instr,
                                 input logic [7:0] acc, input bit expect_frame);
        @(negedge clk);
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
        trace_en    = en;
        debug_pc    = pc;
        debug_instr = instr;
        debug_acc   = acc;
        cap_cyc     = cyc + 1;
        if (expect_frame) pushFrame(pc, instr, acc);
    endtask

    task automatic waitIdle(input int budget, input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || trace_busy) && n < budget) begin
            @(negedge clk);
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            n++;
        end
        checkOutput({"drain_", tag}, 32'(n < budget), 32'd1);
    endtask

    // UART receiver: samples mid-bit, pops the scoreboard on each stop bit.
    initial begin : monitor
        logic [7:0] rx;
        logic       stopv;
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0 && !key0) begin
                if (mon_en) starts_q.push_back(cyc);
                repeat (C / 2) @(negedge clk);
                for (int b = 0; b < 8; b++) begin
                    repeat (C) @(negedge clk);
                    rx[b] = uart_tx;
                end
                repeat (C) @(negedge clk);
                stopv = uart_tx;
                if (mon_en) begin
                    checkOutput("stop_bit", 32'(stopv), 32'd1);
                    if (exp_q.size() == 0)
                        checkOutput("extra_byte", 32'(exp_q.size()), 32'd1);
                    else
                        checkOutput("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin : main
        int quiet_bad;
        int cap0;
        int n;

        repeat (5) @(negedge clk);
        key0 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checkOutput("rst_tx", 32'(uart_tx), 32'd1);
            checkOutput("rst_busy", 32'(trace_busy), 32'd0);
            checkOutput("rst_level", 32'(fifo_level), 32'd0);
            checkOutput("rst_drop", 32'(drop_count), 32'd0);
        end

        $display("[TB] single frame");
        mon_en = 1'b1;
        starts_q.delete();
        applyStimulus(1'b1, 8'h00, 16'h1234, 8'h56, 1'b1);
        cap0 = cap_cyc;
        applyStimulus(1'b1, 8'h01, 16'h1234, 8'h56, 1'b1);
        repeat (5) @(negedge clk);
        checkOutput("busy_in_frame", 32'(trace_busy), 32'd1);
        checkOutput("level_queued", 32'(fifo_level), 32'd1);
        waitIdle(3000, "single");
        checkOutput("start_count", 32'(starts_q.size()), 32'(2 * NB));
        if (starts_q.size() >= 2 * NB) begin
            checkOutput("first_latency", 32'(starts_q[0] - cap0), 32'd3);
            checkOutput("frame_span", 32'(starts_q[NB-1] - starts_q[0]), 32'((NB - 1) * 10 * C));
            checkOutput("frame_period", 32'(starts_q[NB] - starts_q[0]), 32'(NB * 10 * C + 2));
        end

        $display("[TB] burst");
        repeat (10) @(negedge clk);
        applyStimulus(1'b0, 8'h00, 16'h0000, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 16'h0000, 8'h00, 1'b0);
        peak = 0;
        for (int p = 1; p <= 6; p++)
            applyStimulus(1'b1, 8'(p), {8'hC0, 8'(p)}, 8'(p) ^ 8'h3C, p <= 5);
        waitIdle(3000, "burst");
        checkOutput("burst_drop", 32'(drop_count), 32'd1);
        checkOutput("burst_peak", 32'(peak), 32'(DEPTH));
        checkOutput("burst_queue", 32'(exp_q.size()), 32'd0);

        $display("[TB] saturation");
        repeat (10) @(negedge clk);
        mon_en = 1'b0;
        for (int i = 0; i < 300; i++)
            applyStimulus(1'b1, 8'(8'h10 + i), 16'h5555, 8'(i), 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("sat_drop", 32'(drop_count), 32'hFF);
        for (int i = 0; i < 50; i++)
            applyStimulus(1'b1, 8'(8'h80 + i), 16'hAAAA, 8'(i), 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("sat_hold", 32'(drop_count), 32'hFF);
        applyStimulus(1'b0, 8'h00, 16'h0000, 8'h00, 1'b0);
        waitIdle(3000, "sat");
        repeat (50) @(negedge clk);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 8'h00, 16'h0000, 8'h00, 1'b0);
        cap0 = cap_cyc;
        applyStimulus(1'b0, 8'h00, 16'h0000, 8'h00, 1'b0);
        n = 0;
        while (cyc < cap0 + 56 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("mid_wait", 32'(n < 200), 32'd1);
        checkOutput("mid_tx_data", 32'(uart_tx), 32'd0);
        checkOutput("mid_busy", 32'(trace_busy), 32'd1);
        key0 = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_tx", 32'(uart_tx), 32'd1);
        checkOutput("rst_mid_level", 32'(fifo_level), 32'd0);
        checkOutput("rst_mid_busy", 32'(trace_busy), 32'd0);
        checkOutput("rst_mid_drop", 32'(drop_count), 32'd0);
        key0 = 1'b0;
        quiet_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || trace_busy !== 1'b0) quiet_bad++;
        end
        checkOutput("post_reset_quiet", 32'(quiet_bad), 32'd0);

        $display("[TB] re-enable after reset");
        mon_en = 1'b1;
        starts_q.delete();
        applyStimulus(1'b1, 8'h00, 16'hBEEF, 8'h99, 1'b1);
        cap0 = cap_cyc;
        waitIdle(3000, "reenable");
        checkOutput("reen_starts", 32'(starts_q.size()), 32'(NB));
        if (starts_q.size() >= 1)
            checkOutput("reen_latency", 32'(starts_q[0] - cap0), 32'd3);
        checkOutput("final_queue", 32'(exp_q.size()), 32'd0);

        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
